nes_clock_reset_seq: RTL and testbench

Consumer side of the NES PLL. Runs on the 21.6 MHz NES master clock and watches the PLL lock output. It enforces a stabilisation window, then sequences SDRAM reset release and waits for SDRAM init with a timeout. It then releases NES core reset and generates the phase-aligned PPU (/4) and CPU (/12) clock enables. Any loss of lock drops the design back into reset.

---
 rtl/nes_clock_reset_seq.sv | 124 ++++++++++++
 tb/tb_nes_clock_reset_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nes_clock_reset_seq.sv
// NES clock/reset sequencer: waits for PLL lock, stabilises, releases SDRAM, then the NES core,
// and generates the phase-aligned PPU (/4) and CPU (/12) clock enables.
module nes_clock_reset_seq #(
    parameter int unsigned STABLE_CYCLES = 21600,
    parameter int unsigned INIT_TIMEOUT  = 2160000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       sdram_init_done,
    output logic       sdram_rst_n,
    output logic       nes_rst_n,
    output logic       ppu_ce,
    output logic       cpu_ce,
    output logic       ready,
    output logic       lock_lost,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        STABILIZE  = 3'd1,
        SDRAM_INIT = 3'd2,
        RUN        = 3'd3,
        FAULT      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [3:0]       DIV_LAST     = 4'd11;

    logic             sync1;
    logic             lock_s;
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       div;
    logic             lost_q;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= pll_lock;
            lock_s <= sync1;
        end
    end

    // Sequencing FSM; lock loss has priority over every other transition
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st     <= WAIT_LOCK;
            cnt    <= '0;
            div    <= '0;
            lost_q <= 1'b0;
        end else begin
            case (st)
                WAIT_LOCK: begin
                    cnt <= '0;
                    if (lock_s) st <= STABILIZE;
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        st     <= WAIT_LOCK;
                        cnt    <= '0;
                        lost_q <= 1'b1;
                    end else if (cnt == STABLE_LAST) begin
                        st  <= SDRAM_INIT;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SDRAM_INIT: begin
                    if (!lock_s) begin
                        st     <= WAIT_LOCK;
                        cnt    <= '0;
                        lost_q <= 1'b1;
                    end else if (sdram_init_done) begin
                        st  <= RUN;
                        cnt <= '0;
                        div <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        st  <= FAULT;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        st     <= WAIT_LOCK;
                        div    <= '0;
                        lost_q <= 1'b1;
                    end else begin
                        div <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
                    end
                end
                FAULT: begin
                    cnt <= '0;
                end
                default: begin
                    st  <= WAIT_LOCK;
                    cnt <= '0;
                    div <= '0;
                end
            endcase
        end
    end

    // Outputs decode only registered state and divider
    assign state       = st;
    assign sdram_rst_n = (st == SDRAM_INIT) || (st == RUN);
    assign nes_rst_n   = (st == RUN);
    assign ready       = (st == RUN);
    assign fault       = (st == FAULT);
    assign lock_lost   = lost_q;
    assign ppu_ce      = (st == RUN) && (div[1:0] == 2'b11);
    assign cpu_ce      = (st == RUN) && (div == DIV_LAST);

endmodule

// File: tb/tb_nes_clock_reset_seq.sv
// Self-checking bench for nes_clock_reset_seq: directed scenarios plus randomized lock/init
// activity, all compared every cycle against a cycle-counting behavioural model.
module tb_nes_clock_reset_seq;

    localparam int unsigned SC = 8;
    localparam int unsigned IT = 16;
    localparam int unsigned CW = 8;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pll_lock;
    logic       sdram_init_done;
    logic       sdram_rst_n;
    logic       nes_rst_n;
    logic       ppu_ce;
    logic       cpu_ce;
    logic       ready;
    logic       lock_lost;
    logic       fault;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    nes_clock_reset_seq #(.STABLE_CYCLES(SC), .INIT_TIMEOUT(IT), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .pll_lock(pll_lock), .sdram_init_done(sdram_init_done),
        .sdram_rst_n(sdram_rst_n), .nes_rst_n(nes_rst_n), .ppu_ce(ppu_ce), .cpu_ce(cpu_ce),
        .ready(ready), .lock_lost(lock_lost), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase number, cycles spent in the phase, and RUN cycle index
    int m_phase;
    int m_elapsed;
    int m_n;
    bit m_lost;
    bit lock_hist[$];

    function automatic void model_reset();
        m_phase = 0;
        m_elapsed = 0;
        m_n = 0;
        m_lost = 1'b0;
        lock_hist.delete();
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            model_reset();
        end else begin
            bit ls;
            // lock as seen two edges late through the synchroniser
            ls = (lock_hist.size() >= 2) ? lock_hist[lock_hist.size() - 2] : 1'b0;
            lock_hist.push_back(pll_lock);
            if (lock_hist.size() > 4) void'(lock_hist.pop_front());
            if (m_phase != 0 && m_phase != 4 && !ls) begin
                m_phase = 0;
                m_lost = 1'b1;
            end else begin
                case (m_phase)
                    0: if (ls) begin m_phase = 1; m_elapsed = 0; end
                    1: begin
                        m_elapsed++;
                        if (m_elapsed == int'(SC)) begin m_phase = 2; m_elapsed = 0; end
                    end
                    2: begin
                        if (sdram_init_done) begin
                            m_phase = 3;
                            m_n = 0;
                        end else begin
                            m_elapsed++;
                            if (m_elapsed == int'(IT)) m_phase = 4;
                        end
                    end
                    3: m_n++;
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [9:0] model_vec();
        bit run;
        run = (m_phase == 3);
        return {3'(m_phase), (m_phase == 2) || run, run, run && (m_n % 4 == 3),
                run && (m_n % 12 == 11), run, m_lost, m_phase == 4};
    endfunction

    always @(negedge clk) begin
        if (cmp_en)
            check("cycle_outputs",
                  int'({state, sdram_rst_n, nes_rst_n, ppu_ce, cpu_ce, ready, lock_lost, fault}),
                  int'(model_vec()));
    end

    task automatic areset();
        @(negedge clk);
        #2 resetn = 1'b0;
        pll_lock = 1'b0;
        sdram_init_done = 1'b0;
        #1;
        check("areset_state", int'(state), 0);
        check("areset_outs", int'({sdram_rst_n, nes_rst_n, ppu_ce, cpu_ce, ready, lock_lost, fault}), 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // From WAIT_LOCK with lock low: raise lock and verify the full stabilisation window
    task automatic bring_to_init();
        pll_lock = 1'b1;
        repeat (2) @(negedge clk);
        check("still_wait_edge2", int'(state), 0);
        @(negedge clk);
        check("stabilize_edge3", int'(state), 1);
        repeat (7) @(negedge clk);
        check("sdram_low_edge10", int'(sdram_rst_n), 0);
        @(negedge clk);
        check("sdram_high_edge11", int'(sdram_rst_n), 1);
        check("init_state_edge11", int'(state), 2);
    endtask

    int ppu_cnt, cpu_cnt, first_ppu, first_cpu, overlap_err, waited;

    initial begin
        resetn = 1'b0;
        pll_lock = 1'b0;
        sdram_init_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", int'(state), 0);
        check("reset_outs", int'({sdram_rst_n, nes_rst_n, ppu_ce, cpu_ce, ready, lock_lost, fault}), 0);
        resetn = 1'b1;
        cmp_en = 1'b1;

        // Nominal bring-up
        bring_to_init();
        repeat (4) @(negedge clk);
        sdram_init_done = 1'b1;
        check("not_ready_before_done", int'(ready), 0);
        @(negedge clk);
        check("ready_after_done", int'(ready), 1);
        check("nes_rst_after_done", int'(nes_rst_n), 1);

        // Enable cadence over 48 RUN cycles
        ppu_cnt = 0; cpu_cnt = 0; first_ppu = -1; first_cpu = -1; overlap_err = 0;
        for (int n = 0; n < 48; n++) begin
            if (ppu_ce) begin ppu_cnt++; if (first_ppu < 0) first_ppu = n; end
            if (cpu_ce) begin cpu_cnt++; if (first_cpu < 0) first_cpu = n; end
            if (cpu_ce && !ppu_ce) overlap_err++;
            @(negedge clk);
        end
        check("ppu_count", ppu_cnt, 12);
        check("cpu_count", cpu_cnt, 4);
        check("first_ppu", first_ppu, 3);
        check("first_cpu", first_cpu, 11);
        check("cpu_without_ppu", overlap_err, 0);

        // Lock loss in RUN, then re-sequence
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        check("runloss_resets", int'({sdram_rst_n, nes_rst_n, ready}), 0);
        check("runloss_ce", int'({ppu_ce, cpu_ce}), 0);
        check("runloss_lost", int'(lock_lost), 1);
        repeat (2) @(negedge clk);
        pll_lock = 1'b1;
        waited = 0;
        while (!ready && waited < 60) begin @(negedge clk); waited++; end
        check("resequence_ready", int'(ready), 1);
        check("lost_sticky", int'(lock_lost), 1);

        // Async reset mid-RUN
        repeat (5) @(negedge clk);
        areset();

        // Lock drop in STABILIZE at cnt=5
        pll_lock = 1'b1;
        repeat (6) @(negedge clk);
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        check("stab_still_edge8", int'(state), 1);
        check("stab_sdram_low", int'(sdram_rst_n), 0);
        @(negedge clk);
        check("stab_drop_state", int'(state), 0);
        check("stab_drop_lost", int'(lock_lost), 1);
        check("stab_drop_sdram", int'(sdram_rst_n), 0);
        repeat (3) @(negedge clk);
        bring_to_init();

        // SDRAM init timeout
        areset();
        bring_to_init();
        repeat (15) @(negedge clk);
        check("timeout_not_yet", int'(state), 2);
        @(negedge clk);
        check("timeout_fault_state", int'(state), 4);
        check("timeout_fault", int'(fault), 1);
        check("timeout_resets", int'({sdram_rst_n, nes_rst_n}), 0);
        sdram_init_done = 1'b1;
        repeat (3) @(negedge clk);
        pll_lock = 1'b0;
        repeat (4) @(negedge clk);
        pll_lock = 1'b1;
        repeat (6) @(negedge clk);
        check("fault_terminal", int'(state), 4);
        check("fault_no_lost", int'(lock_lost), 0);

        // Randomized lock/init activity with occasional async resets
        areset();
        for (int it = 0; it < 200; it++) begin
            int hold;
            pll_lock = ($urandom_range(0, 3) != 0);
            hold = pll_lock ? int'($urandom_range(5, 80)) : int'($urandom_range(1, 6));
            repeat (hold) begin
                @(negedge clk);
                if ($urandom_range(0, 7) == 0) sdram_init_done = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 19) == 0) areset();
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
